// File: rtl/ldpc_pkg.sv
// Shared LDPC definitions: magnitude limits, CNU normalisation modes and FSM state types.
package ldpc_pkg;

    localparam logic [1:0] CNU_RAW  = 2'd0;
    localparam logic [1:0] CNU_NORM = 2'd1;
    localparam logic [1:0] CNU_OFS  = 2'd2;

    typedef enum logic {ACC, HOLD} acc_state_t;
    typedef enum logic {IDLE, DRAIN} out_state_t;

    function automatic int maxmag(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/cnu_scale.sv
// Combinational min-sum magnitude scaling: raw, 3/4 normalised, or offset clamped at zero.
module cnu_scale
    import ldpc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-2:0] mag,
    input  logic [1:0]        mode,
    input  logic [DATA_W-2:0] beta,
    output logic [DATA_W-2:0] scaled
);

    logic [DATA_W:0] triple;

    assign triple = {2'b00, mag} + {1'b0, mag, 1'b0};

    always_comb begin
        scaled = mag;
        case (mode)
            CNU_NORM: scaled = triple[DATA_W:2];
            CNU_OFS:  scaled = (mag > beta) ? (mag - beta) : '0;
            default:  scaled = mag;
        endcase
    end

endmodule

// File: rtl/cnu_serial.sv
// Serial min-sum check node: accumulates one row while draining the previous one.
//   state | meaning
//   ACC   | accepting beats of the current row
//   HOLD  | finished row parked, waiting for the output bank to free
//   IDLE  | output bank empty
//   DRAIN | streaming check-to-variable messages of the loaded row
module cnu_serial
    import ldpc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 5,
    parameter int DMAX   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] q,
    input  logic              q_valid,
    input  logic              q_last,
    output logic              q_ready,
    input  logic [1:0]        mode,
    input  logic [DATA_W-2:0] beta,
    output logic [DATA_W-1:0] r,
    output logic              r_valid,
    output logic              r_last,
    input  logic              r_ready
);

    localparam int MAXMAG_I = maxmag(DATA_W);
    localparam logic [DATA_W-2:0] MAXMAG = MAXMAG_I[DATA_W-2:0];

    acc_state_t acc_state, acc_state_n;
    out_state_t out_state, out_state_n;

    logic [IDX_W-1:0]  count, hold_last;
    logic [DATA_W-2:0] min1, min2;
    logic [IDX_W-1:0]  idx;
    logic              par;
    logic [DMAX-1:0]   sign_bank;

    logic [DATA_W-2:0] o_min1, o_min2, o_beta;
    logic [IDX_W-1:0]  o_idx, o_last, out_cnt;
    logic              o_par;
    logic [DMAX-1:0]   o_sign;
    logic [1:0]        o_mode;

    logic              sgn;
    logic [DATA_W-1:0] q_neg;
    logic [DATA_W-2:0] mag, n_min1, n_min2;
    logic [IDX_W-1:0]  n_idx;
    logic              n_par;
    logic [DMAX-1:0]   n_sign;

    logic acc_fire, row_end, out_done, out_free, xfer_beat, xfer_hold;

    // Negating the most negative input wraps back to itself, so it saturates instead.
    always_comb begin
        sgn    = q[DATA_W-1];
        q_neg  = -q;
        mag    = q[DATA_W-2:0];
        if (sgn)
            mag = q_neg[DATA_W-1] ? MAXMAG : q_neg[DATA_W-2:0];
        n_min1 = min1;
        n_min2 = min2;
        n_idx  = idx;
        if (mag < min1) begin
            n_min2 = min1;
            n_min1 = mag;
            n_idx  = count;
        end else if (mag < min2) begin
            n_min2 = mag;
        end
        n_par         = par ^ sgn;
        n_sign        = sign_bank;
        n_sign[count] = sgn;
    end

    assign q_ready   = (acc_state == ACC);
    assign r_valid   = (out_state == DRAIN);
    assign acc_fire  = q_valid & q_ready;
    assign row_end   = acc_fire & (q_last | (count == IDX_W'(DMAX - 1)));
    assign out_done  = r_valid & r_ready & (out_cnt == o_last);
    assign out_free  = (out_state == IDLE) | out_done;
    assign xfer_beat = row_end & out_free;
    assign xfer_hold = (acc_state == HOLD) & out_free;

    always_comb begin
        acc_state_n = acc_state;
        out_state_n = out_state;
        case (acc_state)
            ACC:     if (row_end && !out_free) acc_state_n = HOLD;
            HOLD:    if (out_free) acc_state_n = ACC;
            default: acc_state_n = ACC;
        endcase
        if (xfer_beat || xfer_hold)
            out_state_n = DRAIN;
        else if (out_done)
            out_state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_state <= ACC;
            out_state <= IDLE;
        end else begin
            acc_state <= acc_state_n;
            out_state <= out_state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            hold_last <= '0;
            min1      <= MAXMAG;
            min2      <= MAXMAG;
            idx       <= '0;
            par       <= 1'b0;
            sign_bank <= '0;
        end else if (xfer_beat || xfer_hold) begin
            if (xfer_beat)
                count <= '0;
            min1      <= MAXMAG;
            min2      <= MAXMAG;
            idx       <= '0;
            par       <= 1'b0;
            sign_bank <= '0;
        end else if (acc_fire) begin
            // A parked row keeps its final state in the accumulator until transfer.
            count     <= row_end ? '0 : count + IDX_W'(1);
            if (row_end)
                hold_last <= count;
            min1      <= n_min1;
            min2      <= n_min2;
            idx       <= n_idx;
            par       <= n_par;
            sign_bank <= n_sign;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_min1  <= '0;
            o_min2  <= '0;
            o_idx   <= '0;
            o_last  <= '0;
            o_par   <= 1'b0;
            o_sign  <= '0;
            o_mode  <= CNU_RAW;
            o_beta  <= '0;
            out_cnt <= '0;
        end else if (xfer_beat || xfer_hold) begin
            o_min1  <= xfer_beat ? n_min1 : min1;
            o_min2  <= xfer_beat ? n_min2 : min2;
            o_idx   <= xfer_beat ? n_idx : idx;
            o_par   <= xfer_beat ? n_par : par;
            o_sign  <= xfer_beat ? n_sign : sign_bank;
            o_last  <= xfer_beat ? count : hold_last;
            o_mode  <= mode;
            o_beta  <= beta;
            out_cnt <= '0;
        end else if (r_valid && r_ready) begin
            out_cnt <= out_cnt + IDX_W'(1);
        end
    end

    logic [DATA_W-2:0] m_sel, m_s;
    logic [DATA_W-1:0] m_ext, r_val;
    logic              r_sgn;

    assign m_sel = (out_cnt == o_idx) ? o_min2 : o_min1;

    cnu_scale #(.DATA_W(DATA_W)) u_scale (
        .mag    (m_sel),
        .mode   (o_mode),
        .beta   (o_beta),
        .scaled (m_s)
    );

    assign r_sgn  = o_par ^ o_sign[out_cnt];
    assign m_ext  = {1'b0, m_s};
    assign r_val  = r_sgn ? -m_ext : m_ext;
    assign r      = r_valid ? r_val : '0;
    assign r_last = r_valid & (out_cnt == o_last);

endmodule

// File: tb/tb_cnu_serial.sv
// Scoreboard bench for cnu_serial: expected messages queued at stimulus, popped on output handshakes.
module tb_cnu_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] q = '0;
    logic       q_valid = 1'b0;
    logic       q_last = 1'b0;
    logic       q_ready;
    logic [1:0] mode = 2'd0;
    logic [6:0] beta = '0;
    logic [7:0] r;
    logic       r_valid;
    logic       r_last;
    logic       r_ready = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    logic [8:0] sb[$];

    cnu_serial dut (
        .clk     (clk),
        .rst     (rst),
        .q       (q),
        .q_valid (q_valid),
        .q_last  (q_last),
        .q_ready (q_ready),
        .mode    (mode),
        .beta    (beta),
        .r       (r),
        .r_valid (r_valid),
        .r_last  (r_last),
        .r_ready (r_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && r_valid && r_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_r", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                check("r", {24'd0, r}, {24'd0, e[7:0]});
                check("r_last", {31'd0, r_last}, {31'd0, e[8]});
            end
        end
    end

    task automatic push_exp(input int vals[$]);
        for (int i = 0; i < vals.size(); i++) begin
            logic [7:0] v8;
            v8 = vals[i][7:0];
            sb.push_back({(i == vals.size() - 1), v8});
        end
    endtask

    // Reference min-sum straight from the algorithm definition, used for the long row.
    task automatic model_row(input int vals[$], input int md, input int bt);
        int m1, m2, ix, par, m, s;
        int out[$];
        m1 = 127; m2 = 127; ix = 0; par = 0;
        foreach (vals[i]) begin
            int mg;
            mg = (vals[i] < 0) ? ((vals[i] == -128) ? 127 : -vals[i]) : vals[i];
            par ^= (vals[i] < 0);
            if (mg < m1) begin m2 = m1; m1 = mg; ix = i; end
            else if (mg < m2) m2 = mg;
        end
        foreach (vals[i]) begin
            m = (i == ix) ? m2 : m1;
            if (md == 1) m = (3 * m) / 4;
            else if (md == 2) m = (m > bt) ? m - bt : 0;
            s = par ^ (vals[i] < 0);
            out.push_back(s ? -m : m);
        end
        push_exp(out);
    endtask

    task automatic send_beat(input int v, input bit last);
        int n;
        q = v[7:0];
        q_valid = 1'b1;
        q_last = last;
        n = 0;
        @(negedge clk);
        while (!q_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("q_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        q_valid = 1'b0;
        q_last = 1'b0;
    endtask

    task automatic send_row(input int vals[$], input bit use_last);
        foreach (vals[i]) send_beat(vals[i], use_last && (i == vals.size() - 1));
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((sb.size() != 0 || r_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int long_row[$];
        repeat (2) @(posedge clk);
        #1;
        check("rst_r", {24'd0, r}, 32'd0);
        check("rst_r_valid", {31'd0, r_valid}, 32'd0);
        check("rst_r_last", {31'd0, r_last}, 32'd0);
        check("rst_q_ready", {31'd0, q_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        r_ready = 1'b1;

        mode = 2'd1;
        push_exp('{-1, 1, -1, 1, -2, -1, 1, -1});
        send_beat(5, 0); send_beat(-3, 0); send_beat(7, 0); send_beat(-9, 0);
        send_beat(2, 0); send_beat(6, 0); send_beat(-4, 0);
        check("pre_last_r_valid", {31'd0, r_valid}, 32'd0);
        send_beat(8, 1);
        check("first_r_latency", {31'd0, r_valid}, 32'd1);

        mode = 2'd2; beta = 7'd2;
        push_exp('{0, 0, 0, 0, -1, 0, 0, 0});
        send_row('{5, -3, 7, -9, 2, 6, -4, 8}, 1);

        mode = 2'd0;
        push_exp('{10, -127});
        send_row('{-128, 10}, 1);
        push_exp('{127});
        send_row('{-5}, 1);
        push_exp('{4, 4, 4});
        send_row('{4, 4, 9}, 1);

        mode = 2'd3;
        for (int i = 0; i < 32; i++) long_row.push_back(int'($urandom_range(0, 255)) - 128);
        model_row(long_row, 0, 0);
        send_row(long_row, 0);
        wait_empty();

        mode = 2'd0;
        r_ready = 1'b0;
        push_exp('{2, 1, 1});
        send_row('{1, 2, 3}, 1);
        push_exp('{5, -1, -1});
        send_row('{-1, 5, 6}, 1);
        check("bp_q_ready_drop", {31'd0, q_ready}, 32'd0);
        r_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_hold_1", {31'd0, q_ready}, 32'd0);
        @(posedge clk); #1;
        check("bp_hold_2", {31'd0, q_ready}, 32'd0);
        @(posedge clk); #1;
        check("bp_q_ready_rise", {31'd0, q_ready}, 32'd1);
        check("bp_no_bubble", {31'd0, r_valid}, 32'd1);
        wait_empty();

        r_ready = 1'b0;
        send_row('{1, 2, 3}, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_drain_r_valid", {31'd0, r_valid}, 32'd0);
        check("rst_drain_q_ready", {31'd0, q_ready}, 32'd1);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        r_ready = 1'b1;
        send_beat(-7, 0);
        send_beat(1, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_acc_r_valid", {31'd0, r_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        push_exp('{4, 4, 4});
        send_row('{4, 4, 9}, 1);
        wait_empty();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
